store_merge_unit: RTL and testbench
===================================

STORE_MERGE_UNIT -- requirements
Module: store_merge_unit

Interface
REQ-001 Parameter ADDR_WIDTH, default 32, byte-address width of request and memory address ports.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 req_valid  input  1  store request present.
REQ-005 req_ready  output  1  unit can accept a request this cycle.
REQ-006 req_addr  input  ADDR_WIDTH  byte address of store.
REQ-007 req_data  input  32  register value to store (rt).
REQ-008 req_type  input  2  00 = sw, 01 = sh, 10 = sb, 11 = reserved.
REQ-009 mem_addr  output  ADDR_WIDTH  word-aligned address, low 2 bits always 0.
REQ-010 mem_rd_en  output  1  word read request.
REQ-011 mem_rvalid  input  1  mem_rdata valid this cycle.
REQ-012 mem_rdata  input  32  word read from memory.
REQ-013 mem_wr_en  output  1  word write request.
REQ-014 mem_wdata  output  32  merged word to write.
REQ-015 mem_ack  input  1  write accepted this cycle.
REQ-016 done  output  1  one-cycle pulse: store completed.
REQ-017 err  output  1  one-cycle pulse: request rejected (misaligned or reserved type).

Function
REQ-018 States: IDLE, READ, WRITE, RESP; encoding held in shared package.
REQ-019 req_ready SHALL be 1 only in IDLE; a request is accepted when req_valid and req_ready are both 1.
REQ-020 On acceptance, req_addr, req_data, req_type SHALL be latched; later input changes have no effect on the operation.
REQ-021 Misaligned (sw with addr[1:0]!=0, sh with addr[0]=1) or req_type=11: no memory access; next state RESP with err=1, done=0.
REQ-022 Accepted sw: next state WRITE, mem_wdata = latched req_data, no read issued.
REQ-023 Accepted sh/sb: next state READ; mem_rd_en held 1 until the cycle mem_rvalid=1, then WRITE.
REQ-024 Merge, little-endian: sb replaces bits [8k+7:8k] of mem_rdata with req_data[7:0], k = addr[1:0]; sh replaces [15:0] if addr[1]=0, else [31:16], with req_data[15:0]; other bits unchanged.
REQ-025 Merged word SHALL be registered when mem_rvalid=1 and held stable throughout WRITE.
REQ-026 WRITE: mem_wr_en held 1 until the cycle mem_ack=1, then RESP.
REQ-027 RESP: exactly one of done/err is 1 for one cycle; next state IDLE.
REQ-028 mem_addr = {latched addr[ADDR_WIDTH-1:2], 2'b00} in READ and WRITE; 0 otherwise.
REQ-029 mem_rvalid outside READ and mem_ack outside WRITE SHALL be ignored.
REQ-030 mem_rd_en and mem_wr_en SHALL never be 1 in the same cycle.
REQ-031 Minimum latency acceptance->done: sw 2 cycles (ack same cycle as WRITE entry), sh/sb 3 cycles; err 1 cycle.
REQ-032 Back-to-back: new request accepted the cycle after RESP.

Reset
REQ-033 reset=1 SHALL immediately force IDLE, req_ready=1, mem_rd_en=0, mem_wr_en=0, mem_addr=0, mem_wdata=0, done=0, err=0.
REQ-034 Reset mid-READ or mid-WRITE SHALL abort the operation; no done/err for it; memory side outputs drop asynchronously.

Structure
REQ-035 Shared package/macro file holds state encodings and req_type codes (SW/SH/SB) alongside existing EXT op macros.
REQ-036 One combinational sub-module byte_merge (inputs old word, new data, type, addr[1:0]; output merged word), separately testable.

Verification
REQ-037 sw addr 0x100, data 0xDEADBEEF, ack immediate -> one write, mem_addr 0x100, mem_wdata 0xDEADBEEF, no rd_en, done 2 cycles after acceptance.
REQ-038 sb addr 0x203, data 0x000000AB, rdata 0x11223344 -> mem_wdata 0xAB223344 at 0x200; sh addr 0x202, data 0x5566 -> 0x55663344.
REQ-039 sh addr 0x101 and sw addr 0x102 -> err pulse 1 cycle later, no rd_en/wr_en ever asserted.
REQ-040 sb with mem_rvalid delayed 5 cycles and mem_ack delayed 3 -> rd_en held 5 cycles, wr_en held 3, wdata stable, single done.
REQ-041 reset asserted during WRITE with ack withheld -> wr_en falls without clock edge, no done, next request served normally.
REQ-042 Stray mem_rvalid/mem_ack pulses in IDLE and req_data changed mid-operation -> no state change, merged word uses latched data.

Source files
------------

// File: rtl/store_merge_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module      : store_merge_unit_pkg
// Description : Shared encodings for the store merge unit: FSM states,
//               store request types, load-extension op codes and a helper
//               that classifies a request as rejectable.
// Revision    : 1.0 - initial release
// ============================================================================
package store_merge_unit_pkg;

  // FSM state encoding
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  // Store request type codes
  localparam logic [1:0] TYPE_SW  = 2'b00;
  localparam logic [1:0] TYPE_SH  = 2'b01;
  localparam logic [1:0] TYPE_SB  = 2'b10;
  localparam logic [1:0] TYPE_RSV = 2'b11;

  // Load-extension op codes shared with the load path
  localparam logic [2:0] EXT_NONE = 3'd0;
  localparam logic [2:0] EXT_LB   = 3'd1;
  localparam logic [2:0] EXT_LBU  = 3'd2;
  localparam logic [2:0] EXT_LH   = 3'd3;
  localparam logic [2:0] EXT_LHU  = 3'd4;

  // A request is rejected when misaligned for its size or of reserved type
  function automatic logic is_bad_req(input logic [1:0] rtype, input logic [1:0] off);
    case (rtype)
      TYPE_SW: return (off != 2'b00);
      TYPE_SH: return off[0];
      TYPE_SB: return 1'b0;
      default: return 1'b1;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/byte_merge.sv
`default_nettype none
// ============================================================================
// Module      : byte_merge
// Description : Combinational little-endian byte/halfword merge of new store
//               data into an old memory word.
// Revision    : 1.0 - initial release
// ============================================================================
module byte_merge
  import store_merge_unit_pkg::*;
(
  input  logic [31:0] old_word,
  input  logic [31:0] new_data,
  input  logic [1:0]  req_type,
  input  logic [1:0]  byte_off,
  output logic [31:0] merged
);

  // One lane per byte: decide whether the lane is overwritten and by which byte
  for (genvar i = 0; i < 4; i++) begin : g_lane
    localparam logic [1:0] LANE_IDX = 2'(i);
    logic       lane_en;
    logic [7:0] lane_src;

    // Lane enable and source byte selection by store size
    always_comb begin
      lane_en  = 1'b0;
      lane_src = new_data[8*i +: 8];
      case (req_type)
        TYPE_SW: begin
          lane_en  = 1'b1;
          lane_src = new_data[8*i +: 8];
        end
        TYPE_SH: begin
          lane_en  = (byte_off[1] == LANE_IDX[1]);
          lane_src = new_data[8*(i%2) +: 8];
        end
        TYPE_SB: begin
          lane_en  = (byte_off == LANE_IDX);
          lane_src = new_data[7:0];
        end
        default: ;
      endcase
    end

    assign merged[8*i +: 8] = lane_en ? lane_src : old_word[8*i +: 8];
  end

endmodule
`default_nettype wire

// File: rtl/store_merge_unit.sv
`default_nettype none
// ============================================================================
// Module      : store_merge_unit
// Description : Accepts sw/sh/sb store requests, performs read-modify-write
//               for sub-word stores against a word-wide memory port and
//               reports completion (done) or rejection (err).
// Revision    : 1.0 - initial release
// ============================================================================
module store_merge_unit
  import store_merge_unit_pkg::*;
#(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [31:0]           req_data,
  input  logic [1:0]            req_type,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_rd_en,
  input  logic                  mem_rvalid,
  input  logic [31:0]           mem_rdata,
  output logic                  mem_wr_en,
  output logic [31:0]           mem_wdata,
  input  logic                  mem_ack,
  output logic                  done,
  output logic                  err
);

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q,  addr_d;
  logic [31:0]           data_q,  data_d;
  logic [1:0]            type_q,  type_d;
  logic [31:0]           wdata_q, wdata_d;
  logic                  err_q,   err_d;
  logic [31:0]           merged_w;

  byte_merge u_byte_merge (
    .old_word (mem_rdata),
    .new_data (data_q),
    .req_type (type_q),
    .byte_off (addr_q[1:0]),
    .merged   (merged_w)
  );

  // State and latched-request registers; reset aborts any operation in flight
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      data_q  <= '0;
      type_q  <= TYPE_SW;
      wdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      type_q  <= type_d;
      wdata_q <= wdata_d;
      err_q   <= err_d;
    end
  end

  // Next-state and datapath update; request fields only sampled in IDLE
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    data_d  = data_q;
    type_d  = type_q;
    wdata_d = wdata_q;
    err_d   = err_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          addr_d = req_addr;
          data_d = req_data;
          type_d = req_type;
          if (is_bad_req(req_type, req_addr[1:0])) begin
            err_d   = 1'b1;
            state_d = ST_RESP;
          end else begin
            err_d = 1'b0;
            if (req_type == TYPE_SW) begin
              wdata_d = req_data;
              state_d = ST_WRITE;
            end else begin
              state_d = ST_READ;
            end
          end
        end
      end
      ST_READ: begin
        if (mem_rvalid) begin
          wdata_d = merged_w;
          state_d = ST_WRITE;
        end
      end
      ST_WRITE: begin
        if (mem_ack) state_d = ST_RESP;
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs decoded from state only, so they follow reset without a clock
  always_comb begin
    req_ready = (state_q == ST_IDLE);
    mem_rd_en = (state_q == ST_READ);
    mem_wr_en = (state_q == ST_WRITE);
    mem_addr  = '0;
    if (state_q == ST_READ || state_q == ST_WRITE) begin
      mem_addr = {addr_q[ADDR_WIDTH-1:2], 2'b00};
    end
    mem_wdata = (state_q == ST_WRITE) ? wdata_q : 32'd0;
    done      = (state_q == ST_RESP) && !err_q;
    err       = (state_q == ST_RESP) &&  err_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_store_merge_unit.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_store_merge_unit
// Description : Directed self-checking bench for store_merge_unit with a
//               cycle-stepped memory responder and hand-computed results.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_store_merge_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic [31:0] req_data;
  logic [1:0]  req_type;
  logic [31:0] mem_addr;
  logic        mem_rd_en;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        mem_wr_en;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic        done;
  logic        err;

  int total = 0;
  int bad   = 0;

  store_merge_unit #(.ADDR_WIDTH(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_addr   (req_addr),
    .req_data   (req_data),
    .req_type   (req_type),
    .mem_addr   (mem_addr),
    .mem_rd_en  (mem_rd_en),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata),
    .mem_wr_en  (mem_wr_en),
    .mem_wdata  (mem_wdata),
    .mem_ack    (mem_ack),
    .done       (done),
    .err        (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  // Issue one request, play memory with the given delays, then check the run
  task automatic run_store(input string name, input logic [31:0] addr, input logic [31:0] data,
                           input logic [1:0] typ, input int rdelay, input int adelay,
                           input logic [31:0] rdata, input logic exp_err, input logic [31:0] exp_wdata);
    int rd_cnt = 0, wr_cnt = 0, done_cnt = 0, err_cnt = 0, lat = 0;
    int overlap = 0, wbad = 0, abad = 0;
    int exp_rd, exp_wr, exp_lat;
    logic [31:0] exp_addr;
    exp_addr = {addr[31:2], 2'b00};
    exp_rd   = (exp_err || typ == 2'b00) ? 0 : rdelay;
    exp_wr   = exp_err ? 0 : adelay;
    exp_lat  = exp_err ? 1 : exp_rd + adelay + 1;

    @(negedge clk);
    check({name, " ready"}, req_ready, 1);
    req_valid = 1'b1; req_addr = addr; req_data = data; req_type = typ;
    @(negedge clk);
    req_valid = 1'b0; req_data = ~data; req_addr = addr ^ 32'h0000_0F03; req_type = ~typ;
    for (int c = 1; c <= 40; c++) begin
      mem_rvalid = 1'b0; mem_ack = 1'b0; mem_rdata = 32'hFFFF_FFFF;
      if (mem_rd_en && mem_wr_en) overlap++;
      if (mem_rd_en) begin
        rd_cnt++;
        if (mem_addr !== exp_addr) abad++;
        if (rd_cnt == rdelay) begin mem_rvalid = 1'b1; mem_rdata = rdata; end
      end
      if (mem_wr_en) begin
        wr_cnt++;
        if (mem_addr !== exp_addr) abad++;
        if (mem_wdata !== exp_wdata) wbad++;
        if (wr_cnt == adelay) mem_ack = 1'b1;
      end
      if (done) begin done_cnt++; if (lat == 0) lat = c; end
      if (err)  begin err_cnt++;  if (lat == 0) lat = c; end
      if (lat != 0 && c >= lat + 2) break;
      @(negedge clk);
    end
    mem_rvalid = 1'b0; mem_ack = 1'b0;
    check({name, " done count"}, done_cnt, exp_err ? 0 : 1);
    check({name, " err count"}, err_cnt, exp_err ? 1 : 0);
    check({name, " latency"}, lat, exp_lat);
    check({name, " rd_en cycles"}, rd_cnt, exp_rd);
    check({name, " wr_en cycles"}, wr_cnt, exp_wr);
    check({name, " rd/wr overlap"}, overlap, 0);
    check({name, " bad mem_addr cycles"}, abad, 0);
    check({name, " bad wdata cycles"}, wbad, 0);
    check({name, " idle mem_addr"}, mem_addr, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int pulses;
    reset = 1'b1; req_valid = 1'b0; req_addr = '0; req_data = '0; req_type = 2'b00;
    mem_rvalid = 1'b0; mem_rdata = '0; mem_ack = 1'b0;
    #1;
    check("reset ready", req_ready, 1);
    check("reset rd_en", mem_rd_en, 0);
    check("reset wr_en", mem_wr_en, 0);
    check("reset mem_addr", mem_addr, 0);
    check("reset mem_wdata", mem_wdata, 0);
    check("reset done/err", {done, err}, 0);
    @(negedge clk); @(negedge clk);
    reset = 1'b0;

    // Stray memory responses while idle must be ignored
    @(negedge clk);
    mem_rvalid = 1'b1; mem_ack = 1'b1; mem_rdata = 32'h9999_9999;
    @(negedge clk);
    check("stray ready", req_ready, 1);
    check("stray rd/wr", {mem_rd_en, mem_wr_en}, 0);
    check("stray done/err", {done, err}, 0);
    mem_rvalid = 1'b0; mem_ack = 1'b0;

    run_store("sw100",   32'h100, 32'hDEADBEEF, 2'b00, 1, 1, 32'h0,        1'b0, 32'hDEADBEEF);
    run_store("sb203",   32'h203, 32'h000000AB, 2'b10, 1, 1, 32'h11223344, 1'b0, 32'hAB223344);
    run_store("sh202",   32'h202, 32'h00005566, 2'b01, 1, 1, 32'h11223344, 1'b0, 32'h55663344);
    run_store("sh200",   32'h200, 32'hFFFF7788, 2'b01, 1, 1, 32'h11223344, 1'b0, 32'h11227788);
    run_store("sb200",   32'h200, 32'h000000EE, 2'b10, 1, 1, 32'h11223344, 1'b0, 32'h112233EE);
    run_store("sb201",   32'h201, 32'h123456CD, 2'b10, 1, 1, 32'h11223344, 1'b0, 32'h1122CD44);
    run_store("sb202",   32'h202, 32'h00000077, 2'b10, 2, 1, 32'h11223344, 1'b0, 32'h11773344);
    run_store("sw_ack2", 32'h7FC, 32'h01234567, 2'b00, 1, 2, 32'h0,        1'b0, 32'h01234567);
    run_store("sh101",   32'h101, 32'h0000BEEF, 2'b01, 1, 1, 32'h0,        1'b1, 32'h0);
    run_store("sw102",   32'h102, 32'hCAFEBABE, 2'b00, 1, 1, 32'h0,        1'b1, 32'h0);
    run_store("rsv100",  32'h100, 32'h12345678, 2'b11, 1, 1, 32'h0,        1'b1, 32'h0);
    run_store("sb_slow", 32'h300, 32'h0000003C, 2'b10, 5, 3, 32'hA5A5A5A5, 1'b0, 32'hA5A5A53C);

    // Reset while a write is waiting for its acknowledge
    @(negedge clk);
    req_valid = 1'b1; req_addr = 32'h400; req_data = 32'hCAFEF00D; req_type = 2'b00;
    @(negedge clk);
    req_valid = 1'b0;
    check("rstw wr_en before", mem_wr_en, 1);
    check("rstw addr before", mem_addr, 32'h400);
    @(negedge clk);
    check("rstw wr_en held", mem_wr_en, 1);
    #2 reset = 1'b1;
    #1;
    check("rstw wr_en async", mem_wr_en, 0);
    check("rstw mem_addr async", mem_addr, 0);
    check("rstw wdata async", mem_wdata, 0);
    check("rstw ready async", req_ready, 1);
    @(negedge clk);
    reset = 1'b0;
    pulses = 0;
    for (int c = 0; c < 4; c++) begin
      if (done || err || mem_wr_en || mem_rd_en) pulses++;
      @(negedge clk);
    end
    check("rstw no activity after abort", pulses, 0);
    run_store("post_rst", 32'h404, 32'h000000C3, 2'b10, 1, 1, 32'h55555555, 1'b0, 32'h55555555 & 32'hFFFFFF00 | 32'h000000C3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
